post_processing_seq: RTL and testbench
======================================

Name: post_processing_seq

Overview:
- Chunk-serial back end for the 4-bit prefix adder datapath.
- Consumes per-chunk bitwise propagate plus prefix-network group generate/propagate, one 4-bit chunk per beat, LSB chunk first.
- Resolves the inter-chunk carry and produces sum bits.
- Assembles a WIDTH-bit result and carry-out, then presents them on a valid/ready output port.

Parameters:
- WIDTH, 16, result width in bits; must be a multiple of 4, minimum 4.
- NUM_CHUNKS, WIDTH/4, derived number of beats per operation; not overridable.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- in_valid_i  input  1  chunk beat valid.
- in_ready_o  output  1  block can accept a beat.
- carry_i  input  1  operation carry-in; sampled only on the first beat of an operation.
- prop_i  input  4  bitwise propagate a[j]^b[j] of the chunk.
- grp_gen_i  input  4  group generate over chunk bits 0..j, excluding carry-in.
- grp_prop_i  input  4  group propagate over chunk bits 0..j.
- flush_i  input  1  synchronous abort of the current operation.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts result.
- sum_o  output  WIDTH  assembled sum.
- carry_o  output  1  final carry-out.
- ovf_o  output  1  signed overflow; see Optional Feature.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, chunk counter=0, carry register c=0, sum register=0.
  - out_valid_o=0, carry_o=0, ovf_o=0, sum_o=0.
  - in_ready_o=0 while in reset; 1 from the first cycle after release.
- States:
  - IDLE: no operation in progress.
  - ACCUM: k chunks of the current operation accepted, 0<k<NUM_CHUNKS.
  - HOLD: result complete, out_valid_o=1.
- Ready rule: in_ready_o=1 in IDLE and ACCUM; 0 in HOLD.
- A beat is accepted when in_valid_i && in_ready_o.
- Carry-in for the beat (cin):
  - cin = carry_i on the first beat, i.e. accepted in IDLE.
  - cin = c otherwise.
- Per accepted beat:
  - Carry into bit 0 is cin; carry into bit j (j=1..3) = grp_gen_i[j-1] | (grp_prop_i[j-1] & cin).
  - Sum bit j = prop_i[j] ^ carry into bit j.
  - Sum bits are written to sum register bits [4k+3:4k], k = counter value before the beat.
  - c <= grp_gen_i[3] | (grp_prop_i[3] & cin).
  - Counter increments.
- Transitions:
  - IDLE -> ACCUM on an accepted beat when NUM_CHUNKS>1.
  - IDLE -> HOLD on an accepted beat when NUM_CHUNKS==1.
  - ACCUM -> HOLD on the beat that makes counter reach NUM_CHUNKS; counter clears.
  - HOLD -> IDLE on out_valid_o && out_ready_i.
- Latency: out_valid_o rises the cycle after the last beat is accepted. Minimum NUM_CHUNKS+1 cycles from first beat to result; NUM_CHUNKS+2 cycles from first beat to the next accepted first beat.
- Output timing:
  - carry_o = c, registered on the last beat.
  - sum_o and carry_o are stable throughout HOLD.
  - In IDLE and ACCUM, sum_o and carry_o hold intermediate contents and are don't-care to the consumer.
- Backpressure: in HOLD with out_ready_i=0, all outputs are held and incoming beats are not accepted, with no data loss upstream.
- flush_i:
  - In IDLE or ACCUM: state=IDLE, counter=0, c=0; the beat presented in the same cycle is discarded.
  - In HOLD: no effect; the result must be consumed.
- The sum register is not cleared between operations; every bit is rewritten before HOLD.

Optional Feature:
- Macro: POST_PROC_OVF_EN.
- Defined:
  - On the last beat, ovf_o is registered as (carry into bit 3 of that chunk) ^ (chunk carry-out).
  - ovf_o is stable in HOLD and resets to 0.
  - Flush clears it.
- Undefined: ovf_o is tied to 0 and no overflow logic is synthesised.

Test Plan:
- WIDTH=16, bench model derives prop/grp inputs from operands. 0x1234+0x4321, carry_i=0, back-to-back beats, out_ready_i=1 -> sum_o=0x5555, carry_o=0, out_valid_o high exactly 1 cycle, 5 cycles after first beat.
- 0xFFFF+0x0001, carry_i=0 -> sum_o=0x0000, carry_o=1; verifies carry ripple across all 4 beats. 0xFFFF+0x0000 with carry_i=1 -> same result.
- 0x7FFF+0x0001 -> sum_o=0x8000, carry_o=0, ovf_o=1 with POST_PROC_OVF_EN, 0 without. 0x8000+0x8000 -> sum_o=0, carry_o=1, ovf_o=1 / 0.
- Backpressure:
  - Hold out_ready_i=0 for 5 cycles in HOLD with in_valid_i=1 -> in_ready_o=0, sum_o/carry_o unchanged.
  - Release -> handshake, IDLE next cycle, next operation correct.
- Random in_valid_i gaps (0-3 idle cycles between beats) on 100 random operand pairs plus random carry_i -> all results match the model.
- Abort/reset:
  - Assert flush_i after 2 beats -> IDLE, next op 0x0001+0x0001 gives 0x0002.
  - Drop rst_ni after 2 beats -> all outputs 0 immediately, next op correct.

Source files
------------

// File: rtl/post_processing_seq.sv
// ---------------------------------------------------------------------------
// post_processing_seq
//
// Back end of the chunk-serial 4-bit prefix adder. The block takes one 4-bit
// chunk per beat, least significant chunk first. Each beat carries the bitwise
// propagate of the chunk and the group generate/propagate prefixes from the
// prefix network. The block resolves the carry that passes from one chunk to
// the next, forms the sum bits and builds a WIDTH-bit result. When the last
// chunk has been accepted, the result is held on a valid/ready port until the
// consumer takes it.
//
// Optional feature: define POST_PROC_OVF_EN to register the signed overflow
// flag on ovf_o. When the macro is not defined, ovf_o is tied to 0.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   chunk beat valid
//   in_ready_o   block can accept a beat
//   carry_i      operation carry-in, used only on the first beat
//   prop_i       bitwise propagate of the chunk
//   grp_gen_i    group generate over chunk bits 0..j (carry-in excluded)
//   grp_prop_i   group propagate over chunk bits 0..j
//   flush_i      synchronous abort of the operation in progress (not in HOLD)
//   out_valid_o  result valid
//   out_ready_i  consumer accepts result
//   sum_o        assembled sum
//   carry_o      final carry-out
//   ovf_o        signed overflow (POST_PROC_OVF_EN only)
// ---------------------------------------------------------------------------
module post_processing_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             carry_i,
    input  logic [3:0]       prop_i,
    input  logic [3:0]       grp_gen_i,
    input  logic [3:0]       grp_prop_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    localparam int NUM_CHUNKS = WIDTH / 4;
    localparam int CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Carry into each bit of the chunk. Bit 0 gets cin. Bit j gets the
    // group prefix over bits 0..j-1, combined with cin.
    function automatic logic [3:0] chunk_carries(input logic [2:0] gg,
                                                 input logic [2:0] gp,
                                                 input logic       cin);
        logic [3:0] c;
        c[0] = cin;
        for (int j = 1; j < 4; j++) begin
            c[j] = gg[j-1] | (gp[j-1] & cin);
        end
        return c;
    endfunction

    // Carry-out of the whole chunk, which is the carry into the next chunk.
    function automatic logic chunk_cout(input logic gg3, input logic gp3, input logic cin);
        return gg3 | (gp3 & cin);
    endfunction

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic             beat_s;
    logic             last_s;
    logic             cin_s;
    logic [3:0]       carries_s;
    logic             cout_s;
    logic [3:0]       chunk_sum_s;

    assign beat_s      = in_valid_i & in_ready_q;
    assign last_s      = (cnt_q == CW'(NUM_CHUNKS - 1));
    // An accepted beat in IDLE starts a new operation and takes the external carry.
    assign cin_s       = (state_q == ST_IDLE) ? carry_i : c_q;
    assign carries_s   = chunk_carries(grp_gen_i[2:0], grp_prop_i[2:0], cin_s);
    assign cout_s      = chunk_cout(grp_gen_i[3], grp_prop_i[3], cin_s);
    assign chunk_sum_s = prop_i ^ carries_s;

    // Next-state, counter, carry and sum-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sum_d   = sum_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                    c_d     = 1'b0;
                end else if (beat_s) begin
                    for (int i = 0; i < NUM_CHUNKS; i++) begin
                        if (cnt_q == CW'(i)) begin
                            sum_d[4*i +: 4] = chunk_sum_s;
                        end else begin
                            sum_d[4*i +: 4] = sum_q[4*i +: 4];
                        end
                    end
                    c_d = cout_s;
                    if (last_s) begin
                        state_d = ST_HOLD;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        state_d = ST_ACCUM;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
                c_d     = 1'b0;
            end
        endcase
        out_valid_d = (state_d == ST_HOLD);
        in_ready_d  = (state_d != ST_HOLD);
    end

    // State and datapath registers. The handshake outputs are registered from next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            c_q         <= 1'b0;
            sum_q       <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

`ifdef POST_PROC_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: the carry into the MSB differs from the carry out of the MSB.
    always_comb begin
        ovf_d = ovf_q;
        if ((state_q != ST_HOLD) && flush_i) begin
            ovf_d = 1'b0;
        end else if (beat_s && last_s) begin
            ovf_d = carries_s[3] ^ cout_s;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign sum_o       = sum_q;
    assign carry_o     = c_q;

endmodule

// File: tb/tb_post_processing_seq.sv
// ---------------------------------------------------------------------------
// Testbench for post_processing_seq (WIDTH=16). The bench splits operands into
// chunk-level propagate/generate prefixes and compares each result with a plain
// integer-arithmetic reference: sum = a + b + cin.
// ---------------------------------------------------------------------------
module tb_post_processing_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        carry_i = 1'b0;
    logic [3:0]  prop_i = 4'd0;
    logic [3:0]  grp_gen_i = 4'd0;
    logic [3:0]  grp_prop_i = 4'd0;
    logic        flush_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [15:0] sum_o;
    logic        carry_o;
    logic        ovf_o;

    int n_total = 0;
    int n_bad   = 0;

    post_processing_seq #(.WIDTH(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .carry_i(carry_i), .prop_i(prop_i), .grp_gen_i(grp_gen_i), .grp_prop_i(grp_prop_i),
        .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .sum_o(sum_o), .carry_o(carry_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: sum, carry-out and signed overflow from the operands.
    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] full;
        logic        ov;
        full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
`ifdef POST_PROC_OVF_EN
        ov = (a[15] == b[15]) && (full[15] != a[15]);
`else
        ov = 1'b0;
`endif
        return {ov, full};
    endfunction

    // Upstream prefix network: {grp_prop, grp_gen, prop} for chunk k.
    function automatic logic [11:0] chunk_in(input logic [15:0] a, input logic [15:0] b, input int k);
        logic [3:0] p, g, gg, gp;
        for (int j = 0; j < 4; j++) begin
            p[j] = a[4*k+j] ^ b[4*k+j];
            g[j] = a[4*k+j] & b[4*k+j];
        end
        gg[0] = g[0];
        gp[0] = p[0];
        for (int j = 1; j < 4; j++) begin
            gg[j] = g[j] | (p[j] & gg[j-1]);
            gp[j] = p[j] & gp[j-1];
        end
        return {gp, gg, p};
    endfunction

    // Presents chunk k and waits, with a bound, until it is accepted.
    task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic cin,
                             input int k, inout int cyc);
        logic [11:0] ci;
        int          guard;
        ci = chunk_in(a, b, k);
        in_valid_i = 1'b1;
        carry_i    = cin;
        prop_i     = ci[3:0];
        grp_gen_i  = ci[7:4];
        grp_prop_i = ci[11:8];
        guard = 0;
        while (!in_ready_o && guard < 20) begin
            step();
            cyc++;
            guard++;
        end
        if (guard >= 20) check_val("ready_timeout", 32'd0, 32'd1);
        step();
        cyc++;
    endtask

    // Runs one operation and checks the result. Leaves the DUT in HOLD.
    // vcyc is the cycle in which out_valid is first seen; cycle 1 is the cycle of the first beat.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input int max_gap, output int vcyc);
        logic [17:0] exp;
        int          cyc;
        int          guard;
        cyc = 1;
        for (int k = 0; k < 4; k++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(max_gap, 0)) begin
                    in_valid_i = 1'b0;
                    step();
                    cyc++;
                end
            end
            send_beat(a, b, cin, k, cyc);
        end
        in_valid_i = 1'b0;
        guard = 0;
        while (!out_valid_o && guard < 50) begin
            step();
            cyc++;
            guard++;
        end
        vcyc = cyc;
        exp = ref_add(a, b, cin);
        check_val({tag, "_valid"}, {31'd0, out_valid_o}, 32'd1);
        check_val({tag, "_sum"},   {16'd0, sum_o},       {16'd0, exp[15:0]});
        check_val({tag, "_carry"}, {31'd0, carry_o},     {31'd0, exp[16]});
        check_val({tag, "_ovf"},   {31'd0, ovf_o},       {31'd0, exp[17]});
    endtask

    initial begin
        int          vc;
        logic [15:0] sum_hold;
        logic        carry_hold;
        logic [15:0] ra, rb;
        logic        rc;

        // Reset state
        #2;
        check_val("rst_valid", {31'd0, out_valid_o}, 32'd0);
        check_val("rst_ready", {31'd0, in_ready_o},  32'd0);
        check_val("rst_sum",   {16'd0, sum_o},       32'd0);
        check_val("rst_carry", {31'd0, carry_o},     32'd0);
        check_val("rst_ovf",   {31'd0, ovf_o},       32'd0);
        step();
        rst_ni = 1'b1;
        step();
        check_val("ready_after_rst", {31'd0, in_ready_o}, 32'd1);

        // Back-to-back beats, latency, single-cycle valid
        run_op("basic", 16'h1234, 16'h4321, 1'b0, 0, vc);
        check_val("basic_sum_const", {16'd0, sum_o}, 32'h5555);
        check_val("basic_latency", vc, 32'd5);
        step();
        check_val("basic_valid_drop", {31'd0, out_valid_o}, 32'd0);
        check_val("basic_ready_idle", {31'd0, in_ready_o}, 32'd1);

        // Carry ripple and overflow corners
        run_op("ripple1", 16'hFFFF, 16'h0001, 1'b0, 0, vc); step();
        run_op("ripple2", 16'hFFFF, 16'h0000, 1'b1, 0, vc); step();
        run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 0, vc); step();
        run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 0, vc); step();

        // Backpressure: hold the result with a beat waiting upstream
        out_ready_i = 1'b0;
        run_op("bp", 16'hA5A5, 16'h1111, 1'b1, 0, vc);
        sum_hold   = sum_o;
        carry_hold = carry_o;
        in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("bp_ready_low", {31'd0, in_ready_o},  32'd0);
            check_val("bp_valid_hi",  {31'd0, out_valid_o}, 32'd1);
            check_val("bp_sum_hold",  {16'd0, sum_o},       {16'd0, sum_hold});
            check_val("bp_carry_hold",{31'd0, carry_o},     {31'd0, carry_hold});
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        check_val("bp_release_valid", {31'd0, out_valid_o}, 32'd0);
        check_val("bp_release_ready", {31'd0, in_ready_o},  32'd1);
        run_op("bp_next", 16'h0F0F, 16'hF0F1, 1'b0, 0, vc); step();

        // Flush after two beats; the beat presented with flush is dropped
        vc = 0;
        send_beat(16'hFFFF, 16'hFFFF, 1'b1, 0, vc);
        send_beat(16'hFFFF, 16'hFFFF, 1'b1, 1, vc);
        flush_i = 1'b1;
        in_valid_i = 1'b1;
        step();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        check_val("flush_valid", {31'd0, out_valid_o}, 32'd0);
        check_val("flush_ready", {31'd0, in_ready_o},  32'd1);
        run_op("after_flush", 16'h0001, 16'h0001, 1'b0, 0, vc);
        check_val("after_flush_const", {16'd0, sum_o}, 32'h0002);
        step();

        // Reset asserted in the middle of an operation
        vc = 0;
        send_beat(16'h1357, 16'h2468, 1'b1, 0, vc);
        send_beat(16'h1357, 16'h2468, 1'b1, 1, vc);
        in_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check_val("mrst_valid", {31'd0, out_valid_o}, 32'd0);
        check_val("mrst_sum",   {16'd0, sum_o},       32'd0);
        check_val("mrst_carry", {31'd0, carry_o},     32'd0);
        check_val("mrst_ovf",   {31'd0, ovf_o},       32'd0);
        check_val("mrst_ready", {31'd0, in_ready_o},  32'd0);
        step();
        rst_ni = 1'b1;
        step();
        check_val("mrst_ready_back", {31'd0, in_ready_o}, 32'd1);
        run_op("after_rst", 16'h8001, 16'h7FFF, 1'b1, 0, vc); step();

        // Random operands, carry-in and input gaps
        for (int n = 0; n < 100; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            run_op("rand", ra, rb, rc, 3, vc);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
